// File: rtl/seq_match_pkg.sv
// seq_match_pkg: state encoding and width helpers shared by the sequence-match controller files.
package seq_match_pkg;

    typedef enum logic [1:0] {IDLE, MATCH, LOCKOUT} state_e;

    function automatic int step_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int fc_w(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/seq_match_table.sv
// seq_match_table: NUM_STEPS-entry mask/value register file, cleared to match-anything on reset.
module seq_match_table
    import seq_match_pkg::*;
#(
    parameter int NUM_STEPS = 12,
    parameter int IN_W = 4,
    localparam int STEP_W = step_w(NUM_STEPS)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [STEP_W-1:0] waddr_i,
    input  logic [IN_W-1:0]   wmask_i,
    input  logic [IN_W-1:0]   wval_i,
    input  logic [STEP_W-1:0] raddr_i,
    output logic [IN_W-1:0]   rmask_o,
    output logic [IN_W-1:0]   rval_o
);

    typedef struct packed {
        logic [IN_W-1:0] mask;
        logic [IN_W-1:0] val;
    } entry_t;

    entry_t tbl_q [NUM_STEPS];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_STEPS; i++) tbl_q[i] <= '0;
        end else if (we_i && 32'(waddr_i) < NUM_STEPS) begin
            tbl_q[waddr_i] <= '{mask: wmask_i, val: wval_i};
        end
    end

    assign rmask_o = tbl_q[raddr_i].mask;
    assign rval_o  = tbl_q[raddr_i].val;

endmodule

// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: steps qualified samples through a mask/value table with retry, timeout and fail counting.
// Define SEQ_MATCH_LOCKOUT_EN to add the timed LOCKOUT state after MAX_FAIL consecutive failures.
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter int NUM_STEPS   = 12,
    parameter int IN_W        = 4,
    parameter int TIMEOUT_W   = 8,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16,
    localparam int STEP_W = step_w(NUM_STEPS),
    localparam int FC_W   = fc_w(MAX_FAIL)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 cfg_we_i,
    input  logic [STEP_W-1:0]    cfg_addr_i,
    input  logic [IN_W-1:0]      cfg_mask_i,
    input  logic [IN_W-1:0]      cfg_val_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 sample_valid_i,
    input  logic [IN_W-1:0]      sample_i,
    input  logic [TIMEOUT_W-1:0] step_timeout_i,
    output logic                 busy_o,
    output logic [STEP_W-1:0]    step_o,
    output logic                 done_o,
    output logic                 fail_o,
    output logic                 locked_o,
    output logic [FC_W-1:0]      fail_cnt_o
);

    localparam logic [STEP_W-1:0] LAST = STEP_W'(NUM_STEPS - 1);

    if (NUM_STEPS < 2 || NUM_STEPS > 16 || MAX_FAIL < 1 || MAX_FAIL > 7 || LOCK_CYCLES < 1) begin : g_bad_cfg
        $error("seq_match_ctrl: illegal parameter set");
    end

    state_e                state_q;
    logic [STEP_W-1:0]     step_q;
    logic [TIMEOUT_W-1:0]  timer_q;
    logic [FC_W-1:0]       fail_cnt_q, fail_cnt_d;
    logic                  done_q, fail_q;
    logic [IN_W-1:0]       rd_mask, rd_val;
    logic                  hit, miss;

    seq_match_table #(.NUM_STEPS(NUM_STEPS), .IN_W(IN_W)) u_table (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .we_i    (cfg_we_i && state_q == IDLE),
        .waddr_i (cfg_addr_i),
        .wmask_i (cfg_mask_i),
        .wval_i  (cfg_val_i),
        .raddr_i (step_q),
        .rmask_o (rd_mask),
        .rval_o  (rd_val)
    );

    // A valid sample always wins over an expiring timer.
    assign hit        = ((sample_i ^ rd_val) & rd_mask) == '0;
    assign miss       = sample_valid_i ? !hit : (step_timeout_i != '0 && timer_q == '0);
    assign fail_cnt_d = (fail_cnt_q == FC_W'(MAX_FAIL)) ? fail_cnt_q : fail_cnt_q + FC_W'(1);

`ifdef SEQ_MATCH_LOCKOUT_EN
    localparam int LC_W = step_w(LOCK_CYCLES);
    logic [LC_W-1:0] lock_q;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            step_q     <= '0;
            timer_q    <= '0;
            fail_cnt_q <= '0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
`ifdef SEQ_MATCH_LOCKOUT_EN
            lock_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        state_q <= MATCH;
                        step_q  <= '0;
                        timer_q <= step_timeout_i;
                    end
                end
                MATCH: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        step_q  <= '0;
                    end else if (sample_valid_i && hit) begin
                        if (step_q == LAST) begin
                            state_q    <= IDLE;
                            step_q     <= '0;
                            done_q     <= 1'b1;
                            fail_cnt_q <= '0;
                        end else begin
                            step_q  <= step_q + STEP_W'(1);
                            timer_q <= step_timeout_i;
                        end
                    end else if (miss) begin
                        fail_q     <= 1'b1;
                        step_q     <= '0;
                        timer_q    <= step_timeout_i;
                        fail_cnt_q <= fail_cnt_d;
`ifdef SEQ_MATCH_LOCKOUT_EN
                        if (fail_cnt_d == FC_W'(MAX_FAIL)) begin
                            state_q <= LOCKOUT;
                            lock_q  <= LC_W'(LOCK_CYCLES - 1);
                        end
`endif
                    end else if (step_timeout_i != '0) begin
                        timer_q <= timer_q - TIMEOUT_W'(1);
                    end
                end
`ifdef SEQ_MATCH_LOCKOUT_EN
                LOCKOUT: begin
                    if (lock_q == '0) begin
                        state_q    <= IDLE;
                        fail_cnt_q <= '0;
                    end else begin
                        lock_q <= lock_q - LC_W'(1);
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o     = state_q != IDLE;
    assign step_o     = step_q;
    assign done_o     = done_q;
    assign fail_o     = fail_q;
    assign fail_cnt_o = fail_cnt_q;
`ifdef SEQ_MATCH_LOCKOUT_EN
    assign locked_o   = state_q == LOCKOUT;
`else
    assign locked_o   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_match_ctrl.sv
// tb_seq_match_ctrl: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_seq_match_ctrl;

    localparam int NS = 12, IN_W = 4, TW = 8, MF = 3, LC = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1, cfg_we = 1'b0, start = 1'b0, abort = 1'b0, sample_valid = 1'b0;
    logic [3:0] cfg_addr = '0, cfg_mask = '0, cfg_val = '0, sample = '0;
    logic [7:0] step_timeout = '0;
    logic       busy_o, done_o, fail_o, locked_o;
    logic [3:0] step_o;
    logic [1:0] fail_cnt_o;

    seq_match_ctrl #(.NUM_STEPS(NS), .IN_W(IN_W), .TIMEOUT_W(TW), .MAX_FAIL(MF), .LOCK_CYCLES(LC)) dut (
        .clk_i(clk), .reset_i(reset), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_mask_i(cfg_mask), .cfg_val_i(cfg_val), .start_i(start), .abort_i(abort),
        .sample_valid_i(sample_valid), .sample_i(sample), .step_timeout_i(step_timeout),
        .busy_o(busy_o), .step_o(step_o), .done_o(done_o), .fail_o(fail_o),
        .locked_o(locked_o), .fail_cnt_o(fail_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 matching, 2 locked out; wait counts idle cycles since the last reload.
    int mt [NS], vt [NS];
    int m_mode = 0, m_step = 0, m_fc = 0, m_wait = 0, m_lock = 0;
    bit e_done = 0, e_fail = 0;

    function automatic void model_miss();
        e_fail = 1;
        m_step = 0;
        m_wait = 0;
`ifdef SEQ_MATCH_LOCKOUT_EN
        if (m_fc + 1 == MF) begin
            m_mode = 2;
            m_lock = 0;
        end
        m_fc = m_fc + 1;
`else
        m_fc = (m_fc + 1 > MF) ? MF : m_fc + 1;
`endif
    endfunction

    always @(posedge clk) begin
        e_done = 0;
        e_fail = 0;
        if (reset) begin
            m_mode = 0; m_step = 0; m_fc = 0; m_wait = 0; m_lock = 0;
            for (int i = 0; i < NS; i++) begin mt[i] = 0; vt[i] = 0; end
        end else if (m_mode == 0) begin
            if (cfg_we && int'(cfg_addr) < NS) begin
                mt[cfg_addr] = int'(cfg_mask);
                vt[cfg_addr] = int'(cfg_val);
            end
            if (start && !abort) begin m_mode = 1; m_step = 0; m_wait = 0; end
        end else if (m_mode == 1) begin
            if (abort) begin
                m_mode = 0;
                m_step = 0;
            end else if (sample_valid) begin
                m_wait = 0;
                if ((int'(sample) & mt[m_step]) == (vt[m_step] & mt[m_step])) begin
                    if (m_step == NS - 1) begin
                        e_done = 1; m_fc = 0; m_step = 0; m_mode = 0;
                    end else m_step++;
                end else model_miss();
            end else if (step_timeout != 0) begin
                m_wait++;
                if (m_wait > int'(step_timeout)) model_miss();
            end
        end else begin
            m_lock++;
            if (m_lock == LC) begin m_mode = 0; m_fc = 0; end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy_o, int'(m_mode != 0));
            chk("step", step_o, m_step);
            chk("done", done_o, e_done);
            chk("fail", fail_o, e_fail);
            chk("locked", locked_o, int'(m_mode == 2));
            chk("fail_cnt", fail_cnt_o, m_fc);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic arm();
        start = 1; tick(); start = 0;
    endtask

    task automatic feed(input int v);
        sample_valid = 1; sample = v[3:0]; tick(); sample_valid = 0;
    endtask

    task automatic wait_fail(input string name, input int exp_cycles);
        int k = 0;
        do begin tick(); k++; end while (!fail_o && k < 50);
        chk(name, k, exp_cycles);
    endtask

    initial begin
        int n, exp_fc;
        tick();
        chk_en = 1;
        chk("rst_busy", busy_o, 0); chk("rst_step", step_o, 0);
        chk("rst_fc", fail_cnt_o, 0); chk("rst_locked", locked_o, 0);
        reset = 0;

        for (int i = 0; i < NS; i++) begin
            cfg_we = 1; cfg_addr = i[3:0]; cfg_mask = 4'hF; cfg_val = i[3:0]; tick();
        end
        cfg_we = 0;
        arm();
        chk("arm_busy", busy_o, 1);
        for (int i = 0; i < NS; i++) begin
            feed(i);
            if (i < NS - 1) chk("seq_step", step_o, i + 1);
        end
        chk("seq_done", done_o, 1); chk("seq_busy", busy_o, 0); chk("seq_fc", fail_cnt_o, 0);
        tick();
        chk("done_pulse_width", done_o, 0);

        arm(); feed(0); feed(1); feed(7);
        chk("mis_fail", fail_o, 1); chk("mis_step", step_o, 0);
        chk("mis_fc", fail_cnt_o, 1); chk("mis_busy", busy_o, 1);
        for (int i = 0; i < NS; i++) feed(i);
        chk("retry_done", done_o, 1); chk("retry_fc", fail_cnt_o, 0);

        step_timeout = 8'd5;
        arm();
        for (int f = 1; f <= MF; f++) wait_fail("timeout_cycles", 6);
        chk("to_fc", fail_cnt_o, MF);
`ifdef SEQ_MATCH_LOCKOUT_EN
        chk("to_locked", locked_o, 1);
        n = 1; start = 1;
        while (locked_o && n < 100) begin tick(); if (locked_o) n++; end
        start = 0;
        chk("lock_len", n, LC); chk("lock_exit_busy", busy_o, 0); chk("lock_exit_fc", fail_cnt_o, 0);
        exp_fc = 1;
`else
        chk("to_locked", locked_o, 0);
        wait_fail("timeout_sat", 6);
        chk("sat_fc", fail_cnt_o, MF);
        abort = 1; tick(); abort = 0;
        exp_fc = MF;
`endif
        step_timeout = 0;

        abort = 1; start = 1; tick(); abort = 0; start = 0;
        chk("abort_start_idle", busy_o, 0);
        arm(); feed(9);
        for (int i = 0; i < 5; i++) feed(i);
        chk("pre_abort_step", step_o, 5);
        abort = 1; tick(); abort = 0;
        chk("abort_busy", busy_o, 0); chk("abort_step", step_o, 0);
        chk("abort_fail", fail_o, 0); chk("abort_fc", fail_cnt_o, exp_fc);

        arm();
        cfg_we = 1; cfg_addr = 4'd3; cfg_mask = 4'hF; cfg_val = 4'h9; tick(); cfg_we = 0;
        for (int i = 0; i < NS; i++) feed(i);
        chk("busy_write_ignored", done_o, 1);

        arm();
        for (int i = 0; i < 7; i++) feed(i);
        chk("pre_reset_step", step_o, 7);
        reset = 1; tick(); reset = 0;
        chk("rr_busy", busy_o, 0); chk("rr_step", step_o, 0); chk("rr_done", done_o, 0);
        chk("rr_fail", fail_o, 0); chk("rr_fc", fail_cnt_o, 0);
        arm();
        for (int i = 0; i < NS; i++) feed(4'hA);
        chk("cleared_table_done", done_o, 1);

        for (int c = 0; c < 4000; c++) begin
            reset        = ($urandom_range(0, 299) == 0);
            abort        = ($urandom_range(0, 59) == 0);
            start        = ($urandom_range(0, 5) == 0);
            cfg_we       = ($urandom_range(0, 4) == 0);
            cfg_addr     = 4'($urandom_range(0, 15));
            cfg_mask     = 4'($urandom);
            cfg_val      = 4'($urandom);
            sample_valid = ($urandom_range(0, 2) != 0);
            sample       = ($urandom_range(0, 9) < 8) ? 4'(vt[m_step]) : 4'($urandom);
            if (m_mode == 0 && $urandom_range(0, 9) == 0)
                step_timeout = 8'($urandom_range(0, 2) * 3);
            tick();
        end
        reset = 0; abort = 0; start = 0; cfg_we = 0; sample_valid = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
